// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage hazard bundle: decode/writeback status from the pipeline and
// the stall/flush/redirect controls returned by the hazard controller.
interface decode_hazard_ctrl_if;
    logic        ValidD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        UseRs1D;
    logic        UseRs2D;
    logic [4:0]  RdD;
    logic        RegWriteEnD;
    logic        IsBranchTakenD;
    logic        JumpD;
    logic        RegWriteEnW;
    logic [4:0]  RDW;
    logic        StallF;
    logic        StallD;
    logic        BubbleE;
    logic        FlushD;
    logic        RedirectF;
    logic        HangErr;
    logic [31:0] PendingMask;

    modport master (
        output ValidD, Rs1D, Rs2D, UseRs1D, UseRs2D, RdD, RegWriteEnD,
               IsBranchTakenD, JumpD, RegWriteEnW, RDW,
        input  StallF, StallD, BubbleE, FlushD, RedirectF, HangErr, PendingMask
    );

    modport slave (
        input  ValidD, Rs1D, Rs2D, UseRs1D, UseRs2D, RdD, RegWriteEnD,
               IsBranchTakenD, JumpD, RegWriteEnW, RDW,
        output StallF, StallD, BubbleE, FlushD, RedirectF, HangErr, PendingMask
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard hazard controller: per-register pending-write counters gate the
// decode stage, and a stall watchdog flags a pipeline that never drains.
module decode_hazard_ctrl #(
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned MAX_STALL = 15
) (
    input logic                 clk,
    input logic                 rst,
    decode_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [4:0] MAX_STALL_W = 5'(MAX_STALL);

    logic [1:0]  cnt_r      [32];
    logic [1:0]  cntNext_s  [32];
    logic [31:0] pendMask_r;
    logic [31:0] pendMaskNext_s;
    logic        hangErr_r;
    logic        hangErrNext_s;
    state_t      state_r;
    state_t      stateNext_s;
    logic [3:0]  stallCnt_r;
    logic [3:0]  stallCntNext_s;
    logic [3:0]  stallCntInc_s;
    logic        sbErr_s;
    logic        hazard_s;
    logic        issue_s;
    logic        retire_s;
    logic        stall_s;
    logic        redirect_s;

    // A register whose only pending writer retires this cycle is readable when W bypasses into D.
    function automatic logic reg_busy(input logic [1:0] c, input logic [4:0] r,
                                      input logic ret, input logic [4:0] retReg);
        logic b;
        if (c == 2'd0) begin
            b = 1'b0;
        end else if (WB_BYPASS && (c == 2'd1) && ret && (retReg == r)) begin
            b = 1'b0;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    assign retire_s = hz.RegWriteEnW & (hz.RDW != 5'd0);

    // Hazard detection and pipeline-control generation, all forced low in reset.
    always_comb begin
        hazard_s   = 1'b0;
        stall_s    = 1'b0;
        redirect_s = 1'b0;
        if (rst) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = hz.ValidD &
                       ((hz.UseRs1D & reg_busy(cnt_r[hz.Rs1D], hz.Rs1D, retire_s, hz.RDW)) |
                        (hz.UseRs2D & reg_busy(cnt_r[hz.Rs2D], hz.Rs2D, retire_s, hz.RDW)));
            if (hazard_s) begin
                stall_s = 1'b1;
            end else if (hz.ValidD & (hz.IsBranchTakenD | hz.JumpD)) begin
                redirect_s = 1'b1;
            end else begin
                stall_s    = 1'b0;
                redirect_s = 1'b0;
            end
        end
    end

    assign issue_s = hz.ValidD & hz.RegWriteEnD & (hz.RdD != 5'd0) & ~stall_s;

    assign hz.StallF      = stall_s;
    assign hz.StallD      = stall_s;
    assign hz.BubbleE     = stall_s;
    assign hz.FlushD      = redirect_s;
    assign hz.RedirectF   = redirect_s;
    assign hz.HangErr     = hangErr_r;
    assign hz.PendingMask = pendMask_r;

    // Scoreboard next state; saturation or underflow holds the counter and reports an error.
    always_comb begin
        sbErr_s        = 1'b0;
        pendMaskNext_s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            cntNext_s[r] = cnt_r[r];
            if (r == 0) begin
                cntNext_s[r] = 2'd0;
            end else if ((issue_s && (hz.RdD == 5'(r))) && (retire_s && (hz.RDW == 5'(r)))) begin
                cntNext_s[r] = cnt_r[r];
            end else if (issue_s && (hz.RdD == 5'(r))) begin
                if (cnt_r[r] == 2'd3) begin
                    sbErr_s = 1'b1;
                end else begin
                    cntNext_s[r] = cnt_r[r] + 2'd1;
                end
            end else if (retire_s && (hz.RDW == 5'(r))) begin
                if (cnt_r[r] == 2'd0) begin
                    sbErr_s = 1'b1;
                end else begin
                    cntNext_s[r] = cnt_r[r] - 2'd1;
                end
            end else begin
                cntNext_s[r] = cnt_r[r];
            end
            pendMaskNext_s[r] = (cntNext_s[r] != 2'd0);
        end
    end

    assign stallCntInc_s = (stallCnt_r == 4'hF) ? 4'hF : (stallCnt_r + 4'd1);

    // Stall watchdog FSM: counts consecutive hazard cycles, ERR is terminal until reset.
    always_comb begin
        stateNext_s    = state_r;
        stallCntNext_s = stallCnt_r;
        case (state_r)
            RUN: begin
                if (hazard_s) begin
                    stateNext_s    = STALL;
                    stallCntNext_s = stallCntInc_s;
                end else begin
                    stallCntNext_s = 4'd0;
                end
            end
            STALL: begin
                if (hazard_s) begin
                    stallCntNext_s = stallCntInc_s;
                    if ({1'b0, stallCntInc_s} >= MAX_STALL_W) begin
                        stateNext_s = ERR;
                    end else begin
                        stateNext_s = STALL;
                    end
                end else begin
                    stateNext_s    = RUN;
                    stallCntNext_s = 4'd0;
                end
            end
            ERR: begin
                stateNext_s = ERR;
                if (hazard_s) begin
                    stallCntNext_s = stallCntInc_s;
                end else begin
                    stallCntNext_s = 4'd0;
                end
            end
            default: begin
                stateNext_s    = RUN;
                stallCntNext_s = 4'd0;
            end
        endcase
        hangErrNext_s = hangErr_r | sbErr_s | (stateNext_s == ERR);
    end

    // State registers; reset drops every pending entry along with the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= 2'd0;
            end
            pendMask_r <= 32'd0;
            hangErr_r  <= 1'b0;
            state_r    <= RUN;
            stallCnt_r <= 4'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= cntNext_s[r];
            end
            pendMask_r <= pendMaskNext_s;
            hangErr_r  <= hangErrNext_s;
            state_r    <= stateNext_s;
            stallCnt_r <= stallCntNext_s;
        end
    end
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: two instances (W bypass on and off)
// receive identical stimulus and are checked against hand-derived values.
module tb_decode_hazard_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    decode_hazard_ctrl_if ifc1 ();
    decode_hazard_ctrl_if ifc0 ();

    decode_hazard_ctrl #(.WB_BYPASS(1'b1), .MAX_STALL(15)) dutByp (.clk(clk), .rst(rst), .hz(ifc1));
    decode_hazard_ctrl #(.WB_BYPASS(1'b0), .MAX_STALL(15)) dutNoByp (.clk(clk), .rst(rst), .hz(ifc0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setD(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic br, input logic jmp);
        ifc1.ValidD = v;  ifc1.Rs1D = rs1; ifc1.UseRs1D = u1; ifc1.Rs2D = rs2; ifc1.UseRs2D = u2;
        ifc1.RdD = rd; ifc1.RegWriteEnD = we; ifc1.IsBranchTakenD = br; ifc1.JumpD = jmp;
        ifc0.ValidD = v;  ifc0.Rs1D = rs1; ifc0.UseRs1D = u1; ifc0.Rs2D = rs2; ifc0.UseRs2D = u2;
        ifc0.RdD = rd; ifc0.RegWriteEnD = we; ifc0.IsBranchTakenD = br; ifc0.JumpD = jmp;
    endtask

    task automatic setW(input logic we, input logic [4:0] rd);
        ifc1.RegWriteEnW = we; ifc1.RDW = rd;
        ifc0.RegWriteEnW = we; ifc0.RDW = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setD(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        setW(1'b0, 5'd0);
        tick();
        tick();
        #1;
        checks++;
        if ({ifc1.StallF, ifc1.StallD, ifc1.BubbleE, ifc1.FlushD, ifc1.RedirectF} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_comb_outputs: got %b expected 00000",
                     {ifc1.StallF, ifc1.StallD, ifc1.BubbleE, ifc1.FlushD, ifc1.RedirectF});
        end
        checks++;
        if ({ifc1.HangErr, ifc1.PendingMask} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state: got hang=%b mask=%h expected 0/0", ifc1.HangErr, ifc1.PendingMask);
        end
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    // addi x5 in cycle 0, taken beq x5,x0 from cycle 1, W retires x5 in cycle 4.
    task automatic test_raw_back_to_back();
        int stalls1;
        int stalls0;
        stalls1 = 0;
        stalls0 = 0;
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        setW(1'b0, 5'd0);
        #1;
        checks++;
        if (ifc1.StallD !== 1'b0) begin
            errors++;
            $display("FAIL raw_producer_stall: got %b expected 0", ifc1.StallD);
        end
        tick();
        checks++;
        if (ifc1.PendingMask[5] !== 1'b1 || ifc0.PendingMask[5] !== 1'b1) begin
            errors++;
            $display("FAIL raw_mask_set: got %b/%b expected 1/1", ifc1.PendingMask[5], ifc0.PendingMask[5]);
        end
        for (int c = 1; c <= 5; c++) begin
            setD(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
            setW(c == 4, (c == 4) ? 5'd5 : 5'd0);
            #1;
            if (ifc1.StallD === 1'b1) stalls1++;
            if (ifc0.StallD === 1'b1) stalls0++;
            checks++;
            if ({ifc1.StallF, ifc1.StallD, ifc1.BubbleE, ifc1.FlushD, ifc1.RedirectF} !==
                ((c <= 3) ? 5'b11100 : 5'b00011)) begin
                errors++;
                $display("FAIL raw_byp_ctrl cycle %0d: got %b expected %b", c,
                         {ifc1.StallF, ifc1.StallD, ifc1.BubbleE, ifc1.FlushD, ifc1.RedirectF},
                         (c <= 3) ? 5'b11100 : 5'b00011);
            end
            checks++;
            if ({ifc0.StallF, ifc0.StallD, ifc0.BubbleE, ifc0.FlushD, ifc0.RedirectF} !==
                ((c <= 4) ? 5'b11100 : 5'b00011)) begin
                errors++;
                $display("FAIL raw_nobyp_ctrl cycle %0d: got %b expected %b", c,
                         {ifc0.StallF, ifc0.StallD, ifc0.BubbleE, ifc0.FlushD, ifc0.RedirectF},
                         (c <= 4) ? 5'b11100 : 5'b00011);
            end
            tick();
        end
        checks++;
        if (stalls1 != 3 || stalls0 != 4) begin
            errors++;
            $display("FAIL raw_stall_count: got %0d/%0d expected 3/4", stalls1, stalls0);
        end
        checks++;
        if (ifc1.PendingMask[5] !== 1'b0 || ifc0.PendingMask[5] !== 1'b0) begin
            errors++;
            $display("FAIL raw_mask_clear: got %b/%b expected 0/0", ifc1.PendingMask[5], ifc0.PendingMask[5]);
        end
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        setW(1'b0, 5'd0);
        tick();
    endtask

    task automatic test_jump_and_invalid();
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if ({ifc1.StallD, ifc1.FlushD, ifc1.RedirectF} !== 3'b011) begin
            errors++;
            $display("FAIL jump_redirect: got %b expected 011", {ifc1.StallD, ifc1.FlushD, ifc1.RedirectF});
        end
        tick();
        checks++;
        if (ifc1.PendingMask !== 32'd0) begin
            errors++;
            $display("FAIL x0_write_ignored: got %h expected 0", ifc1.PendingMask);
        end
        setD(1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({ifc1.StallD, ifc1.FlushD, ifc1.RedirectF} !== 3'b000) begin
            errors++;
            $display("FAIL invalid_no_ctrl: got %b expected 000", {ifc1.StallD, ifc1.FlushD, ifc1.RedirectF});
        end
        tick();
        checks++;
        if (ifc1.PendingMask !== 32'd0) begin
            errors++;
            $display("FAIL invalid_no_issue: got %h expected 0", ifc1.PendingMask);
        end
    endtask

    task automatic test_same_cycle();
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        setW(1'b0, 5'd0);
        tick();
        setW(1'b1, 5'd7);
        tick();
        checks++;
        if (ifc1.PendingMask[7] !== 1'b1 || ifc0.PendingMask[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_mask: got %b/%b expected 1/1", ifc1.PendingMask[7], ifc0.PendingMask[7]);
        end
        setD(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        setW(1'b0, 5'd0);
        #1;
        checks++;
        if (ifc1.StallD !== 1'b1 || ifc0.StallD !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_dep_stall: got %b/%b expected 1/1", ifc1.StallD, ifc0.StallD);
        end
        tick();
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        setW(1'b1, 5'd7);
        tick();
        setW(1'b0, 5'd0);
        checks++;
        if (ifc1.PendingMask[7] !== 1'b0 || ifc1.HangErr !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_drain: got mask=%b hang=%b expected 0/0", ifc1.PendingMask[7], ifc1.HangErr);
        end
    endtask

    task automatic test_hang();
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            setD(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            tick();
            if (k == 14) begin
                checks++;
                if (ifc1.HangErr !== 1'b0) begin
                    errors++;
                    $display("FAIL hang_early: got %b expected 0", ifc1.HangErr);
                end
            end
            if (k == 15) begin
                checks++;
                if (ifc1.HangErr !== 1'b1 || ifc0.HangErr !== 1'b1) begin
                    errors++;
                    $display("FAIL hang_rise: got %b/%b expected 1/1", ifc1.HangErr, ifc0.HangErr);
                end
            end
        end
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (ifc1.HangErr !== 1'b1 || ifc1.StallD !== 1'b0) begin
            errors++;
            $display("FAIL hang_sticky: got hang=%b stall=%b expected 1/0", ifc1.HangErr, ifc1.StallD);
        end
    endtask

    task automatic test_reset_mid_stall();
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        setD(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifc1.StallD !== 1'b1 || ifc1.HangErr !== 1'b1 || ifc1.PendingMask[3] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got stall=%b hang=%b pend=%b expected 1/1/1",
                     ifc1.StallD, ifc1.HangErr, ifc1.PendingMask[3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc1.StallD !== 1'b0) begin
            errors++;
            $display("FAIL stall_during_rst: got %b expected 0", ifc1.StallD);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ifc1.PendingMask !== 32'd0 || ifc1.HangErr !== 1'b0 || ifc0.PendingMask !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_state: got mask=%h hang=%b expected 0/0", ifc1.PendingMask, ifc1.HangErr);
        end
        checks++;
        if (ifc1.StallD !== 1'b0 || ifc0.StallD !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_dep_x3: got %b/%b expected 0/0", ifc1.StallD, ifc0.StallD);
        end
        tick();
        checks++;
        if (ifc1.HangErr !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_run: got %b expected 0", ifc1.HangErr);
        end
    endtask

    task automatic test_counter_limits();
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        setW(1'b1, 5'd12);
        tick();
        setW(1'b0, 5'd0);
        checks++;
        if (ifc1.HangErr !== 1'b1 || ifc1.PendingMask[12] !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got hang=%b pend=%b expected 1/0", ifc1.HangErr, ifc1.PendingMask[12]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setD(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (ifc1.HangErr !== 1'b0 || ifc1.PendingMask[13] !== 1'b1) begin
            errors++;
            $display("FAIL count_to_three: got hang=%b pend=%b expected 0/1", ifc1.HangErr, ifc1.PendingMask[13]);
        end
        tick();
        checks++;
        if (ifc1.HangErr !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got %b expected 1", ifc1.HangErr);
        end
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        setW(1'b0, 5'd0);
        test_reset();
        test_raw_back_to_back();
        test_jump_and_invalid();
        test_same_cycle();
        test_hang();
        test_reset_mid_stall();
        test_counter_limits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
